// File: rtl/conv_kxk_stream.sv
// Streaming KxK multi-channel convolution engine.
// Raster-order pixels enter through a valid/ready port, every input channel is
// kept in its own line-buffer shift register, and each valid KxK window yields
// one saturated (optionally ReLU'd) output pixel through a two-stage pipeline.
module conv_kxk_stream #(
  parameter int IN_WIDTH    = 8,
  parameter int OUT_WIDTH   = 8,
  parameter int IMAGE       = 32,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNELS    = 1,
  parameter int STRIDE      = 1,
  parameter int FRAC_BITS   = 0,
  parameter int RELU_EN     = 1,
  localparam int NUM_W      = KERNEL_SIZE * KERNEL_SIZE * CHANNELS,
  localparam int ADDR_W     = $clog2(NUM_W)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  input  logic                         wt_we,
  input  logic [ADDR_W-1:0]            wt_addr,
  input  logic [IN_WIDTH-1:0]          wt_data,
  input  logic                         bias_we,
  input  logic [IN_WIDTH-1:0]          bias_data,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*IN_WIDTH-1:0] in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [OUT_WIDTH-1:0]         out_data,
  output logic                         out_last
);

  localparam int K        = KERNEL_SIZE;
  localparam int ACC_W    = 2 * IN_WIDTH + $clog2(NUM_W) + 1;
  localparam int PROD_W   = 2 * IN_WIDTH;
  localparam int SR_LEN   = (K - 1) * IMAGE + K;
  localparam int CNT_W    = (IMAGE > 1) ? $clog2(IMAGE) : 1;
  // Row/column of the last window the stride grid actually lands on.
  localparam int LAST_POS = (K - 1) + ((IMAGE - K) / STRIDE) * STRIDE;

  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                      state;
  logic [CNT_W-1:0]            col;
  logic [CNT_W-1:0]            row;
  logic signed [IN_WIDTH-1:0]  wts [NUM_W];
  logic signed [IN_WIDTH-1:0]  bias;
  logic signed [IN_WIDTH-1:0]  sr [CHANNELS][SR_LEN];

  logic                        v0, l0, v1, l1;
  logic signed [ACC_W-1:0]     acc_s1;
  logic signed [ACC_W-1:0]     mac_sum;
  logic signed [PROD_W-1:0]    prod;
  logic signed [ACC_W-1:0]     shifted;
  logic signed [OUT_WIDTH-1:0] res;

  logic adv, accept, win_hit, win_last, frame_end;
  int   r_off, c_off;

  assign adv      = !out_valid || out_ready;
  assign in_ready = (state == RUN) && adv;
  assign accept   = in_valid && in_ready;

  // Classify the beat being offered: does it complete a window on the stride grid.
  always_comb begin
    r_off     = int'(row) - (K - 1);
    c_off     = int'(col) - (K - 1);
    win_hit   = (r_off >= 0) && (c_off >= 0) && (r_off % STRIDE == 0) && (c_off % STRIDE == 0);
    win_last  = (int'(row) == LAST_POS) && (int'(col) == LAST_POS);
    frame_end = (int'(row) == IMAGE - 1) && (int'(col) == IMAGE - 1);
  end

  // Frame control: a frame runs until the final beat, then drains the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (accept && frame_end) state <= DRAIN;
        end
        DRAIN: begin
          if (!v0 && !v1 && (!out_valid || out_ready)) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  // Raster position of the next beat; rewound whenever a frame starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col <= '0;
      row <= '0;
    end else if (state == IDLE && start) begin
      col <= '0;
      row <= '0;
    end else if (accept) begin
      if (col == CNT_W'(IMAGE - 1)) begin
        col <= '0;
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Weight and bias file, writable only while no frame is in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_W; i++) wts[i] <= '0;
      bias <= '0;
    end else if (state == IDLE) begin
      if (wt_we && int'(wt_addr) < NUM_W) wts[wt_addr] <= wt_data;
      if (bias_we) bias <= bias_data;
    end
  end

  // Per-channel line buffer: K-1 full rows plus K pixels, newest at index 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < CHANNELS; c++)
        for (int i = 0; i < SR_LEN; i++) sr[c][i] <= '0;
    end else if (accept) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sr[c][0] <= in_data[c*IN_WIDTH +: IN_WIDTH];
        for (int i = 1; i < SR_LEN; i++) sr[c][i] <= sr[c][i-1];
      end
    end
  end

  // Multiply-accumulate across the whole window; pixel (ky,kx) sits
  // (K-1-ky) rows and (K-1-kx) columns behind the newest beat.
  always_comb begin
    prod    = '0;
    mac_sum = ACC_W'(bias);
    for (int c = 0; c < CHANNELS; c++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++) begin
          prod    = PROD_W'(sr[c][(K-1-ky)*IMAGE + (K-1-kx)]) * PROD_W'(wts[c*K*K + ky*K + kx]);
          mac_sum = mac_sum + ACC_W'(prod);
        end
  end

  // Scale, saturate to the output range, then optionally rectify.
  always_comb begin
    shifted = acc_s1 >>> FRAC_BITS;
    if (shifted > SAT_MAX)      res = {1'b0, {(OUT_WIDTH-1){1'b1}}};
    else if (shifted < SAT_MIN) res = {1'b1, {(OUT_WIDTH-1){1'b0}}};
    else                        res = shifted[OUT_WIDTH-1:0];
    if (RELU_EN != 0 && res[OUT_WIDTH-1]) res = '0;
  end

  // Window flag, accumulator and output register all move together only on adv,
  // so a stalled consumer freezes the whole pipe without losing anything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v0        <= 1'b0;
      l0        <= 1'b0;
      v1        <= 1'b0;
      l1        <= 1'b0;
      acc_s1    <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_data  <= '0;
    end else if (adv) begin
      v0        <= accept && win_hit;
      l0        <= accept && win_hit && win_last;
      v1        <= v0;
      l1        <= l0;
      acc_s1    <= mac_sum;
      out_valid <= v1;
      out_last  <= v1 && l1;
      if (v1) out_data <= res;
    end
  end

endmodule

// File: tb/tb_conv_kxk_stream.sv
// Bench for conv_kxk_stream: four instances (stride/ReLU/shift variants) share
// the stimulus, one is selected per frame; a scoreboard queue holds expected pixels.
module tb_conv_kxk_stream;

  localparam int IMG = 8;
  localparam int K   = 3;
  localparam int NW  = 18;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0, wt_we = 1'b0, bias_we = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic [4:0]  wt_addr = '0;
  logic [7:0]  wt_data = '0, bias_data = '0;
  logic [15:0] in_data = '0;
  logic [1:0]  sel = '0;

  logic o_busy [4], o_done [4], o_in_ready [4], o_valid [4], o_last [4];
  logic signed [7:0] o_data [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    conv_kxk_stream #(
      .IN_WIDTH(8), .OUT_WIDTH(8), .IMAGE(IMG), .KERNEL_SIZE(K), .CHANNELS(2),
      .STRIDE(g >= 2 ? 2 : 1), .FRAC_BITS(g == 3 ? 2 : 0), .RELU_EN(g == 1 ? 0 : 1)
    ) dut (
      .clk(clk), .rst(rst), .start(start && (sel == 2'(g))),
      .busy(o_busy[g]), .done(o_done[g]),
      .wt_we(wt_we), .wt_addr(wt_addr), .wt_data(wt_data),
      .bias_we(bias_we), .bias_data(bias_data),
      .in_valid(in_valid && (sel == 2'(g))), .in_ready(o_in_ready[g]), .in_data(in_data),
      .out_valid(o_valid[g]), .out_ready(out_ready), .out_data(o_data[g]), .out_last(o_last[g])
    );
  end

  logic obs_busy, obs_done, obs_in_ready, obs_valid, obs_last;
  logic signed [7:0] obs_data;
  assign obs_busy     = o_busy[sel];
  assign obs_done     = o_done[sel];
  assign obs_in_ready = o_in_ready[sel];
  assign obs_valid    = o_valid[sel];
  assign obs_last     = o_last[sel];
  assign obs_data     = o_data[sel];

  typedef struct { logic signed [7:0] data; logic last; } exp_t;
  typedef struct { int sel; int wt; int bias; int pix; int exp_val; int exp_cnt; } vec_t;

  exp_t exp_q [$];
  exp_t mon_e;
  int errors = 0, checks = 0, cyc = 0, rk = 0;
  bit mon_en = 1'b0, rnd_mode = 1'b0, stalled_prev = 1'b0;
  logic signed [7:0] held_data = '0;
  int n_out, done_cnt, done_cyc, last_acc_cyc, first_valid_cyc, acc18_cyc;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Consumer side: pops the scoreboard on each handshake, checks stall behaviour.
  always @(negedge clk) begin
    if (rst && mon_en) begin
      if (stalled_prev) begin
        check_output("hold_valid", int'(obs_valid), 1);
        check_output("hold_data", int'(obs_data), int'(held_data));
      end
      if (obs_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (obs_valid && out_ready) begin
        if (exp_q.size() == 0) check_output("unexpected_output", 1, 0);
        else begin
          mon_e = exp_q.pop_front();
          check_output("out_data", int'(obs_data), int'(mon_e.data));
          check_output("out_last", int'(obs_last), int'(mon_e.last));
        end
        n_out++;
        if (obs_last) last_acc_cyc = cyc;
      end
      if (obs_valid && !out_ready) check_output("in_ready_stall", int'(obs_in_ready), 0);
      stalled_prev = obs_valid && !out_ready;
      held_data    = obs_data;
      if (obs_done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end else begin
      stalled_prev = 1'b0;
    end
  end

  // Consumer readiness: always ready, or random with a forced 10-cycle stall.
  always begin
    @(posedge clk);
    #2;
    if (rnd_mode) begin
      rk++;
      out_ready = (rk >= 30 && rk < 40) ? 1'b0 : 1'($urandom_range(0, 1));
    end else begin
      out_ready = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input int w, input int b, input bit centre);
    for (int a = 0; a < NW; a++) begin
      wt_we   = 1'b1;
      wt_addr = 5'(a);
      wt_data = 8'(centre ? (a == 4 ? 1 : 0) : w);
      tick();
    end
    wt_we     = 1'b0;
    bias_we   = 1'b1;
    bias_data = 8'(b);
    tick();
    bias_we = 1'b0;
  endtask

  task automatic push_expected(input int s, input int val, input bit raster);
    exp_t e;
    int last_pos;
    last_pos = 2 + ((IMG - K) / s) * s;
    for (int r = 0; r < IMG; r++)
      for (int c = 0; c < IMG; c++)
        if (r >= 2 && c >= 2 && (r - 2) % s == 0 && (c - 2) % s == 0) begin
          e.data = 8'(raster ? (((r - 1) * IMG + (c - 1)) % 128) + 5 : val);
          e.last = (r == last_pos) && (c == last_pos);
          exp_q.push_back(e);
        end
  endtask

  task automatic apply_stimulus(input int idx, input bit raster, input int pix);
    logic [7:0] p;
    p = 8'(raster ? idx % 128 : pix);
    in_valid = 1'b1;
    in_data  = {p, p};
    for (int t = 0; t < 1000; t++) begin
      @(negedge clk);
      if (obs_in_ready) break;
    end
    if (!obs_in_ready) begin
      check_output("beat_accept_timeout", 0, 1);
      in_valid = 1'b0;
      return;
    end
    tick();
    if (idx == 18) acc18_cyc = cyc;
    in_valid = 1'b0;
  endtask

  task automatic run_frame(input int s_sel, input int pix, input bit raster, input int exp_cnt,
                           input bit chk_timing, input bit mid_writes);
    n_out = 0; done_cnt = 0; first_valid_cyc = -1; last_acc_cyc = -1; done_cyc = -1; acc18_cyc = -1;
    sel    = 2'(s_sel);
    mon_en = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    check_output("busy_after_start", int'(obs_busy), 1);
    if (mid_writes) begin
      for (int a = 0; a < NW; a++) begin
        wt_we = 1'b1; wt_addr = 5'(a); wt_data = 8'd3;
        tick();
      end
      wt_we = 1'b0; bias_we = 1'b1; bias_data = 8'd50;
      tick();
      bias_we = 1'b0;
    end
    for (int i = 0; i < IMG * IMG; i++) apply_stimulus(i, raster, pix);
    for (int t = 0; t < 500 && done_cnt == 0; t++) @(negedge clk);
    repeat (4) @(negedge clk);
    check_output("out_count", n_out, exp_cnt);
    check_output("queue_empty", exp_q.size(), 0);
    check_output("done_pulses", done_cnt, 1);
    check_output("busy_idle", int'(obs_busy), 0);
    if (chk_timing) begin
      check_output("latency", first_valid_cyc - acc18_cyc, 2);
      if (s_sel < 2) check_output("done_after_last", done_cyc - last_acc_cyc, 1);
    end
    exp_q.delete();
    mon_en = 1'b0;
  endtask

  initial begin
    vec_t tbl [6];
    tbl[0] = '{sel: 0, wt: 1,   bias: 0, pix: 1,   exp_val: 18,  exp_cnt: 36};
    tbl[1] = '{sel: 0, wt: 127, bias: 0, pix: 127, exp_val: 127, exp_cnt: 36};
    tbl[2] = '{sel: 0, wt: -1,  bias: 0, pix: 1,   exp_val: 0,   exp_cnt: 36};
    tbl[3] = '{sel: 1, wt: -1,  bias: 0, pix: 1,   exp_val: -18, exp_cnt: 36};
    tbl[4] = '{sel: 2, wt: 1,   bias: 0, pix: 1,   exp_val: 18,  exp_cnt: 9};
    tbl[5] = '{sel: 3, wt: 1,   bias: 0, pix: 1,   exp_val: 4,   exp_cnt: 9};

    rst = 1'b0;
    repeat (3) tick();
    check_output("reset_outputs", int'({o_busy[0], o_done[0], o_in_ready[0], o_valid[0], o_last[0], o_data[0]}), 0);
    rst = 1'b1;
    tick();

    // Uniform-image vectors across the four variants.
    for (int i = 0; i < 6; i++) begin
      load_weights(tbl[i].wt, tbl[i].bias, 1'b0);
      push_expected(tbl[i].sel >= 2 ? 2 : 1, tbl[i].exp_val, 1'b0);
      run_frame(tbl[i].sel, tbl[i].pix, 1'b0, tbl[i].exp_cnt, 1'b1, 1'b0);
    end

    // Raster-index image through a centre-tap kernel with bias.
    load_weights(0, 5, 1'b1);
    push_expected(1, 0, 1'b1);
    run_frame(0, 0, 1'b1, 36, 1'b1, 1'b0);

    // Random backpressure with a long stall.
    load_weights(1, 0, 1'b0);
    push_expected(1, 18, 1'b0);
    rk = 0;
    rnd_mode = 1'b1;
    run_frame(0, 1, 1'b0, 36, 1'b0, 1'b0);
    rnd_mode = 1'b0;
    tick();

    // Weight and bias writes while running must not land.
    push_expected(1, 18, 1'b0);
    run_frame(0, 1, 1'b0, 36, 1'b1, 1'b1);

    // Reset part-way through a frame.
    sel = 2'd0;
    push_expected(1, 18, 1'b0);
    n_out = 0; done_cnt = 0; first_valid_cyc = -1;
    mon_en = 1'b1;
    start  = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 0; i < 20; i++) apply_stimulus(i, 1'b0, 1);
    tick();
    check_output("pre_reset_valid", int'(obs_valid), 1);
    #2 rst = 1'b0;
    #1 check_output("midframe_reset_outputs",
                    int'({o_busy[0], o_done[0], o_in_ready[0], o_valid[0], o_last[0], o_data[0]}), 0);
    mon_en = 1'b0;
    exp_q.delete();
    tick();
    rst = 1'b1;
    tick();

    // Cleared weights give zeros; reloading restores the baseline result.
    push_expected(1, 0, 1'b0);
    run_frame(0, 1, 1'b0, 36, 1'b1, 1'b0);
    load_weights(1, 0, 1'b0);
    push_expected(1, 18, 1'b0);
    run_frame(0, 1, 1'b0, 36, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
